vector_vector_alu_sat: RTL

//  Per-chain vector-vector ALU with on-chip vector register file (VVRF), second generation.

---
 rtl/vector_vector_alu_sat_if.sv | 34 +++
 rtl/vector_vector_alu_sat.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_vector_alu_sat_if.sv
// Streaming vector and configuration bus of vector_vector_alu_sat.
// The master drives the vector stream and config bytes; the slave returns results.
interface vector_vector_alu_sat_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4
);
    localparam int CHW = $clog2(MAX_CHAINS);

    logic                           tracing;
    logic                           valid_in;
    logic [1:0]                     eof_in;
    logic [1:0]                     bof_in;
    logic [CHW-1:0]                 chainId_in;
    logic [7:0]                     configId;
    logic [7:0]                     configData;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
    logic [CHW-1:0]                 chainId_out;
    logic                           valid_out;
    logic [1:0]                     eof_out;
    logic [1:0]                     bof_out;
    logic [N-1:0]                   overflow_out;

    modport master (
        output tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
        input  vector_out, chainId_out, valid_out, eof_out, bof_out, overflow_out
    );

    modport slave (
        input  tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
        output vector_out, chainId_out, valid_out, eof_out, bof_out, overflow_out
    );
endinterface

// File: rtl/vector_vector_alu_sat.sv
// Per-chain vector-vector ALU with a vector register file (VVRF), optional saturation,
// signed/unsigned lanes and per-lane overflow flags. Two-stage pipeline, one vector per cycle.
module vector_vector_alu_sat #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int VVVRF_SIZE         = 8,
    parameter int SIGNED             = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    vector_vector_alu_sat_if.slave  bus
);
    localparam int DW       = DATA_WIDTH;
    localparam int CHW      = $clog2(MAX_CHAINS);
    localparam int AW       = $clog2(VVVRF_SIZE);
    localparam int FW_BYTES = 5 * MAX_CHAINS;
    localparam int CW       = $clog2(FW_BYTES + 1);

    localparam logic [DW-1:0] SAT_HI = (SIGNED != 0) ? {1'b0, {(DW-1){1'b1}}} : {DW{1'b1}};
    localparam logic [DW-1:0] SAT_LO = (SIGNED != 0) ? {1'b1, {(DW-1){1'b0}}} : {DW{1'b0}};

    typedef logic [N-1:0][DW-1:0] vec_t;

    // op keeps only the saturate bit and the operation select: {op[7], op[2:0]}
    typedef struct packed {
        logic [3:0]    op;
        logic [AW-1:0] addr_rd;
        logic [7:0]    cond;
        logic          cache_en;
        logic [AW-1:0] cache_addr;
    } fw_t;

    fw_t             fw_q [MAX_CHAINS];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cfg_sel, cfg_wr;
    logic [2:0]      fw_field;
    logic [CHW-1:0]  fw_idx;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        cnt_d    = cnt_q;
        cfg_sel  = (bus.configId == 8'(PERSONAL_CONFIG_ID));
        cfg_wr   = cfg_sel && !bus.tracing && (cnt_q < CW'(FW_BYTES));
        fw_field = 3'(cnt_q / CW'(MAX_CHAINS));
        fw_idx   = CHW'(cnt_q % CW'(MAX_CHAINS));
        if (!cfg_sel) begin
            cnt_d = '0;
        end else if (cfg_wr) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) fw_q[c] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (cfg_wr) begin
                case (fw_field)
                    3'd0:    fw_q[fw_idx].op         <= {bus.configData[7], bus.configData[2:0]};
                    3'd1:    fw_q[fw_idx].addr_rd    <= bus.configData[AW-1:0];
                    3'd2:    fw_q[fw_idx].cond       <= bus.configData;
                    3'd3:    fw_q[fw_idx].cache_en   <= (bus.configData != 8'd0);
                    3'd4:    fw_q[fw_idx].cache_addr <= bus.configData[AW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Stage 1: capture the vector with its chain's firmware fields
    logic           s1_valid_q;
    vec_t           s1_vec_q;
    logic [1:0]     s1_eof_q, s1_bof_q;
    logic [CHW-1:0] s1_chain_q;
    fw_t            s1_fw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_vec_q   <= '0;
            s1_eof_q   <= '0;
            s1_bof_q   <= '0;
            s1_chain_q <= '0;
            s1_fw_q    <= '0;
        end else begin
            s1_valid_q <= bus.valid_in && bus.tracing;
            s1_vec_q   <= bus.vector_in;
            s1_eof_q   <= bus.eof_in;
            s1_bof_q   <= bus.bof_in;
            s1_chain_q <= bus.chainId_in;
            s1_fw_q    <= fw_q[bus.chainId_in];
        end
    end

    // Returns {overflow, lane result}; a is the incoming lane, b the VVRF operand.
    function automatic logic [DW:0] alu_lane(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW:0]     ext_a, ext_b, sum, dif, mag;
        logic [2*DW-1:0] wide_a, wide_b, prod;
        logic [DW-1:0]   res, sat;
        logic            a_gt_b, ovf;
        ext_a  = (SIGNED != 0) ? {a[DW-1], a} : {1'b0, a};
        ext_b  = (SIGNED != 0) ? {b[DW-1], b} : {1'b0, b};
        wide_a = (SIGNED != 0) ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
        wide_b = (SIGNED != 0) ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
        sum    = ext_a + ext_b;
        dif    = ext_a - ext_b;
        mag    = dif[DW] ? -dif : dif;
        prod   = wide_a * wide_b;
        a_gt_b = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
        res    = a;
        sat    = SAT_HI;
        ovf    = 1'b0;
        case (op[2:0])
            3'd1: begin
                res = sum[DW-1:0];
                ovf = (SIGNED != 0) ? (sum[DW] ^ sum[DW-1]) : sum[DW];
                if (SIGNED != 0 && sum[DW]) sat = SAT_LO;
            end
            3'd2: begin
                res = prod[DW-1:0];
                ovf = (SIGNED != 0) ? (prod[2*DW-1:DW-1] != '0 && prod[2*DW-1:DW-1] != '1)
                                    : (prod[2*DW-1:DW] != '0);
                if (SIGNED != 0 && prod[2*DW-1]) sat = SAT_LO;
            end
            3'd3: res = a_gt_b ? a : b;
            3'd4: begin
                res = dif[DW-1:0];
                ovf = (SIGNED != 0) ? (dif[DW] ^ dif[DW-1]) : dif[DW];
                if (dif[DW]) sat = SAT_LO;
            end
            3'd5: res = a_gt_b ? b : a;
            3'd6: begin
                res = mag[DW-1:0];
                ovf = (SIGNED != 0) && (mag[DW:DW-1] != 2'b00);
            end
            default: res = a;
        endcase
        return {ovf, (op[3] && ovf) ? sat : res};
    endfunction

    // Stage 2: VVRF read, cond select and compute
    vec_t           vvrf_q [VVVRF_SIZE];
    vec_t           opnd, result;
    logic [N-1:0]   ovf;
    logic           cond_ok, s2_fire;
    logic [DW:0]    lane;

    always_comb begin
        opnd   = vvrf_q[s1_fw_q.addr_rd];
        result = s1_vec_q;
        ovf    = '0;
        lane   = '0;
        case (s1_fw_q.cond)
            8'd0:    cond_ok = 1'b1;
            8'd1:    cond_ok = s1_eof_q[0];
            8'd2:    cond_ok = !s1_eof_q[0];
            8'd3:    cond_ok = s1_bof_q[0];
            8'd4:    cond_ok = !s1_bof_q[0];
            8'd5:    cond_ok = s1_eof_q[1];
            8'd6:    cond_ok = !s1_eof_q[1];
            8'd7:    cond_ok = s1_bof_q[1];
            8'd8:    cond_ok = !s1_bof_q[1];
            default: cond_ok = 1'b0;
        endcase
        for (int i = 0; i < N; i++) begin
            lane = alu_lane(s1_fw_q.op, s1_vec_q[i], opnd[i]);
            if (cond_ok) begin
                result[i] = lane[DW-1:0];
                ovf[i]    = lane[DW];
            end
        end
        s2_fire = s1_valid_q && bus.tracing;
    end

    logic           valid_out_q;
    vec_t           vector_out_q;
    logic [CHW-1:0] chain_out_q;
    logic [1:0]     eof_out_q, bof_out_q;
    logic [N-1:0]   ovf_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q  <= 1'b0;
            vector_out_q <= '0;
            chain_out_q  <= '0;
            eof_out_q    <= '0;
            bof_out_q    <= '0;
            ovf_out_q    <= '0;
            // NOTE: the VVRF must read 0 after reset, so it is cleared here and stays in flops.
            for (int e = 0; e < VVVRF_SIZE; e++) vvrf_q[e] <= '0;
        end else begin
            valid_out_q <= s2_fire;
            if (s2_fire) begin
                vector_out_q <= result;
                chain_out_q  <= s1_chain_q;
                eof_out_q    <= s1_eof_q;
                bof_out_q    <= s1_bof_q;
                ovf_out_q    <= ovf;
                if (s1_fw_q.cache_en) vvrf_q[s1_fw_q.cache_addr] <= result;
            end
        end
    end

    assign bus.valid_out    = valid_out_q;
    assign bus.vector_out   = vector_out_q;
    assign bus.chainId_out  = chain_out_q;
    assign bus.eof_out      = eof_out_q;
    assign bus.bof_out      = bof_out_q;
    assign bus.overflow_out = ovf_out_q;
endmodule
